// File: rtl/syndrome_collector.sv
// syndrome_collector
// Packs I consecutive parity-check results (F_value, 1 = satisfied) into one
// I-bit syndrome word. A bit is 1 where the check failed. The block also
// computes the word's weight (the number of failed checks) and queues each
// finished word in a small output FIFO with a valid/ready interface.
// Upstream cannot be stalled, so when the FIFO is full a finished word is
// dropped and the sticky overflow flag is set.
//
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   F_value          check result, qualified by F_value_tvalid
//   frame_clear      throw away the partially collected word
//   syndrome         head word of the FIFO (zero when the FIFO is empty)
//   syndrome_weight  popcount of the head word (zero when empty)
//   syndrome_zero    head word has weight 0 (low when empty)
//   syndrome_tvalid  FIFO is not empty
//   syndrome_tready  consumer takes the head word
//   overflow         sticky flag: a finished word was dropped
//   row_cnt          index of the next expected check
module syndrome_collector #(
   parameter int I         = 7,
   parameter int OUT_DEPTH = 2,
   localparam int WWIDTH   = $clog2(I + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   F_value,
   input  logic                   F_value_tvalid,
   input  logic                   frame_clear,
   output logic [I-1:0]           syndrome,
   output logic [WWIDTH-1:0]      syndrome_weight,
   output logic                   syndrome_zero,
   output logic                   syndrome_tvalid,
   input  logic                   syndrome_tready,
   output logic                   overflow,
   output logic [$clog2(I)-1:0]   row_cnt
);

   localparam int RCW = $clog2(I);
   localparam int PW  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam int CW  = $clog2(OUT_DEPTH + 1);

   logic [I-1:0]      partial;
   logic [WWIDTH-1:0] pweight;
   logic              fail;
   logic              accept;
   logic              last_row;
   logic [I-1:0]      word_next;
   logic [WWIDTH-1:0] weight_next;

   logic [I-1:0]      mem_syn [OUT_DEPTH];
   logic [WWIDTH-1:0] mem_wt  [OUT_DEPTH];
   logic [PW-1:0]     rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
   logic [CW-1:0]     count;
   logic              pop, push, drop;

   // Keep the inversion in its own 1-bit signal. If it were written inline,
   // the bit would be widened first and then inverted.
   assign fail        = ~F_value;
   assign accept      = F_value_tvalid && !frame_clear;
   assign last_row    = accept && (row_cnt == RCW'(I - 1));
   assign word_next   = partial | (I'(fail) << row_cnt);
   assign weight_next = pweight + WWIDTH'(fail);

   // Pop is evaluated before push. A full FIFO that is being drained in the
   // same cycle still has room for the incoming word.
   assign pop  = (count != '0) && syndrome_tready;
   assign push = last_row && ((count < CW'(OUT_DEPTH)) || pop);
   assign drop = last_row && !push;

   assign rd_ptr_nxt = (rd_ptr == PW'(OUT_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
   assign wr_ptr_nxt = (wr_ptr == PW'(OUT_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         row_cnt  <= '0;
         partial  <= '0;
         pweight  <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         // The partial word restarts after a completion even when that word
         // was dropped.
         if (frame_clear || last_row) begin
            row_cnt <= '0;
            partial <= '0;
            pweight <= '0;
         end else if (accept) begin
            row_cnt <= row_cnt + 1'b1;
            partial <= word_next;
            pweight <= weight_next;
         end

         if (push) wr_ptr <= wr_ptr_nxt;
         if (pop)  rd_ptr <= rd_ptr_nxt;

         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;

         if (drop) overflow <= 1'b1;
      end
   end

   // The storage needs no reset. Every output read from it is gated by
   // syndrome_tvalid.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem_syn[wr_ptr] <= word_next;
         mem_wt[wr_ptr]  <= weight_next;
      end
   end

   assign syndrome_tvalid = (count != '0);
   assign syndrome        = syndrome_tvalid ? mem_syn[rd_ptr] : '0;
   assign syndrome_weight = syndrome_tvalid ? mem_wt[rd_ptr]  : '0;
   assign syndrome_zero   = syndrome_tvalid && (mem_wt[rd_ptr] == '0);

endmodule

// File: tb/tb_syndrome_collector.sv
// Bench for syndrome_collector. Each finished word is modelled from the list of
// check results received so far. Words the model expects to be stored go into
// a scoreboard queue. A separate monitor compares the DUT output against that
// queue and pops an entry on every handshake.
module tb_syndrome_collector;
   localparam int I         = 7;
   localparam int OUT_DEPTH = 2;
   localparam int WW        = $clog2(I + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          F_value = 1'b0;
   logic          F_value_tvalid = 1'b0;
   logic          frame_clear = 1'b0;
   logic [I-1:0]  syndrome;
   logic [WW-1:0] syndrome_weight;
   logic          syndrome_zero;
   logic          syndrome_tvalid;
   logic          syndrome_tready = 1'b0;
   logic          overflow;
   logic [$clog2(I)-1:0] row_cnt;

   syndrome_collector #(.I(I), .OUT_DEPTH(OUT_DEPTH)) dut (
      .clk(clk), .rst(rst), .F_value(F_value), .F_value_tvalid(F_value_tvalid),
      .frame_clear(frame_clear), .syndrome(syndrome), .syndrome_weight(syndrome_weight),
      .syndrome_zero(syndrome_zero), .syndrome_tvalid(syndrome_tvalid),
      .syndrome_tready(syndrome_tready), .overflow(overflow), .row_cnt(row_cnt)
   );

   always #5 clk = ~clk;

   typedef struct { logic [I-1:0] syn; int wt; } word_t;

   word_t sb[$];
   bit    bits[$];
   int    occ = 0;
   bit    m_ovf = 1'b0;
   bit    started = 1'b0;
   int    n_cmp = 0, n_bad = 0;

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model, updated at each rising edge from the inputs as they
   // stand at that edge.
   always @(posedge clk) begin
      if (rst) begin
         bits.delete(); sb.delete(); occ = 0; m_ovf = 1'b0;
      end else begin
         if (occ > 0 && syndrome_tready) occ--;
         if (frame_clear) bits.delete();
         else if (F_value_tvalid) begin
            bits.push_back(F_value);
            if (bits.size() == I) begin
               if (occ < OUT_DEPTH) begin
                  word_t w;
                  w.syn = '0; w.wt = 0;
                  for (int k = 0; k < I; k++)
                     if (!bits[k]) begin w.syn[k] = 1'b1; w.wt++; end
                  sb.push_back(w);
                  occ++;
               end else m_ovf = 1'b1;
               bits.delete();
            end
         end
      end
   end

   // Monitor: samples on the falling edge
   always @(negedge clk) begin
      if (started) begin
         cmp("tvalid", syndrome_tvalid, occ != 0);
         cmp("overflow", overflow, m_ovf);
         cmp("row_cnt", row_cnt, bits.size());
         if (syndrome_tvalid) begin
            if (sb.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL sb_empty: DUT valid word %0h with nothing expected", syndrome);
            end else begin
               cmp("syndrome", syndrome, sb[0].syn);
               cmp("weight", syndrome_weight, sb[0].wt);
               cmp("zero", syndrome_zero, sb[0].wt == 0);
               if (syndrome_tready) void'(sb.pop_front());
            end
         end else begin
            cmp("idle_syndrome", syndrome, 0);
            cmp("idle_weight", syndrome_weight, 0);
            cmp("idle_zero", syndrome_zero, 0);
         end
      end
   end

   task automatic step(); @(posedge clk); #1; endtask
   task automatic send(input bit f);
      F_value = f; F_value_tvalid = 1'b1; step(); F_value_tvalid = 1'b0;
   endtask
   task automatic idle(input int n); for (int k = 0; k < n; k++) step(); endtask
   task automatic do_reset(); rst = 1'b1; step(); rst = 1'b0; endtask

   initial begin
      #500000;
      $display("FAIL watchdog: run did not finish (got timeout, required finish)");
      $fatal(1, "watchdog");
   end

   initial begin
      bit pat[7] = '{1, 0, 1, 1, 0, 1, 1};
      step(); step();
      rst = 1'b0;
      started = 1'b1;
      cmp("reset_tvalid", syndrome_tvalid, 0);
      cmp("reset_row_cnt", row_cnt, 0);

      // All checks pass
      for (int k = 0; k < I; k++) send(1'b1);
      cmp("t1_tvalid", syndrome_tvalid, 1);
      cmp("t1_syndrome", syndrome, 0);
      cmp("t1_zero", syndrome_zero, 1);
      syndrome_tready = 1'b1; step(); syndrome_tready = 1'b0;
      cmp("t1_popped", syndrome_tvalid, 0);

      // Mixed pattern with random gaps
      syndrome_tready = 1'b1;
      for (int k = 0; k < I; k++) begin send(pat[k]); idle($urandom_range(0, 3)); end
      idle(2);

      // Overflow: three frames while the consumer stalls
      syndrome_tready = 1'b0;
      for (int k = 0; k < 3 * I; k++) send($urandom_range(0, 1));
      cmp("t3_overflow", overflow, 1);
      syndrome_tready = 1'b1; idle(4);
      cmp("t3_overflow_sticky", overflow, 1);

      // FIFO full, with a pop on the same edge as the push
      do_reset();
      syndrome_tready = 1'b0;
      for (int k = 0; k < 3 * I - 1; k++) send($urandom_range(0, 1));
      syndrome_tready = 1'b1; send(1'b0);
      cmp("t4_no_overflow", overflow, 0);
      idle(4);

      // frame_clear together with the 4th input
      for (int k = 0; k < 3; k++) send(1'b1);
      frame_clear = 1'b1; send(1'b0); frame_clear = 1'b0;
      cmp("t5_row_cnt", row_cnt, 0);
      cmp("t5_no_word", syndrome_tvalid, 0);
      for (int k = 0; k < I; k++) send(1'b0);
      cmp("t5_syndrome", syndrome, 7'h7f);
      cmp("t5_weight", syndrome_weight, 7);
      idle(2);

      // Reset mid-frame with a word still pending
      syndrome_tready = 1'b0;
      for (int k = 0; k < I + 4; k++) send($urandom_range(0, 1));
      do_reset();
      cmp("t6_tvalid", syndrome_tvalid, 0);
      cmp("t6_row_cnt", row_cnt, 0);
      syndrome_tready = 1'b1;
      for (int k = 0; k < I; k++) send($urandom_range(0, 1));
      idle(2);

      // Random traffic
      for (int c = 0; c < 4000; c++) begin
         rst            = ($urandom % 500) == 0;
         frame_clear    = ($urandom % 25) == 0;
         F_value_tvalid = ($urandom % 3) != 0;
         F_value        = ($urandom % 4) != 0;
         syndrome_tready = ((c / 200) % 2 == 0) ? (($urandom % 4) != 0) : (($urandom % 4) == 0);
         step();
      end
      rst = 1'b0; frame_clear = 1'b0; F_value_tvalid = 1'b0; syndrome_tready = 1'b1;
      idle(10);
      cmp("sb_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
